// File: rtl/shot_sequencer.sv
// Shot sequencer: arms the direction counters, waits for all four sensors (or a timeout),
// freezes the counters, then rejects echoes for a holdoff period before handing off to the host.
module shot_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 16000,
  parameter int unsigned HOLDOFF_CYC = 8000,
  parameter int unsigned TMR_W       = 16
) (
  input  logic       clk,
  input  logic       ares,
  input  logic       arm,
  input  logic       ack,
  input  logic       abort,
  input  logic       auto_rearm,
  input  logic [3:0] run,
  output logic       clear_cnt,
  output logic       stop_cnt,
  output logic       ready,
  output logic [3:0] miss_mask,
  output logic [7:0] shot_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StMeasure = 3'd2,
    StCapture = 3'd3,
    StHoldoff = 3'd4,
    StDone    = 3'd5
  } state_e;

  localparam logic [TMR_W-1:0] TimeoutVal = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] HoldoffVal = TMR_W'(HOLDOFF_CYC);
  localparam logic [TMR_W-1:0] TimerMax   = '1;
  localparam logic [TMR_W-1:0] TimerOne   = TMR_W'(1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic             clear_q, clear_d;
  logic             blank_q;
  logic             stop_q, stop_d;
  logic             ready_q, ready_d;
  logic [3:0]       miss_q, miss_d;
  logic [7:0]       count_q, count_d;
  logic             run_ok;

  // Counters are still clearing during the clear pulse and the cycle after it.
  assign run_ok    = !(clear_q || blank_q);
  assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + TimerOne;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clear_d = 1'b0;
    stop_d  = 1'b0;
    ready_d = ready_q;
    miss_d  = miss_q;
    count_d = count_q;
    if (abort) begin
      state_d = StIdle;
      timer_d = '0;
      ready_d = 1'b0;
      stop_d  = (state_q == StArmed) || (state_q == StMeasure);
    end else begin
      case (state_q)
        StIdle: begin
          if (arm) begin
            clear_d = 1'b1;
            state_d = StArmed;
            timer_d = '0;
          end
        end
        StArmed: begin
          if (run_ok && (run != 4'h0)) begin
            state_d = StMeasure;
            timer_d = TimerOne;
          end
        end
        StMeasure: begin
          timer_d = timer_inc;
          // Capture results are registered on entry so they are visible during CAPTURE.
          if ((run == 4'hF) || (timer_q == TimeoutVal)) begin
            state_d = StCapture;
            stop_d  = 1'b1;
            miss_d  = ~run;
            count_d = count_q + 8'd1;
            ready_d = 1'b1;
          end
        end
        StCapture: begin
          state_d = StHoldoff;
          timer_d = TimerOne;
        end
        StHoldoff: begin
          if (timer_q == HoldoffVal) begin
            state_d = StDone;
          end else begin
            timer_d = timer_inc;
          end
        end
        StDone: begin
          if (arm || auto_rearm) begin
            ready_d = 1'b0;
            clear_d = 1'b1;
            state_d = StArmed;
            timer_d = '0;
          end else if (ack) begin
            ready_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      state_q <= StIdle;
      timer_q <= '0;
      clear_q <= 1'b0;
      blank_q <= 1'b0;
      stop_q  <= 1'b0;
      ready_q <= 1'b0;
      miss_q  <= 4'h0;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      clear_q <= clear_d;
      blank_q <= clear_q;
      stop_q  <= stop_d;
      ready_q <= ready_d;
      miss_q  <= miss_d;
      count_q <= count_d;
    end
  end

  assign clear_cnt  = clear_q;
  assign stop_cnt   = stop_q;
  assign ready      = ready_q;
  assign miss_mask  = miss_q;
  assign shot_count = count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer with shortened timers so the 256-shot wrap stays short.
module tb_shot_sequencer;

  localparam int unsigned TimeoutCyc = 50;
  localparam int unsigned HoldoffCyc = 12;

  logic       clk = 1'b0;
  logic       ares = 1'b1;
  logic       arm = 1'b0;
  logic       ack = 1'b0;
  logic       abort = 1'b0;
  logic       auto_rearm = 1'b0;
  logic [3:0] run = 4'h0;
  logic       clear_cnt, stop_cnt, ready;
  logic [3:0] miss_mask;
  logic [7:0] shot_count;
  logic [2:0] state;

  int nvec = 0;
  int nerr = 0;

  shot_sequencer #(
    .TIMEOUT_CYC(TimeoutCyc),
    .HOLDOFF_CYC(HoldoffCyc),
    .TMR_W      (16)
  ) dut (
    .clk       (clk),
    .ares      (ares),
    .arm       (arm),
    .ack       (ack),
    .abort     (abort),
    .auto_rearm(auto_rearm),
    .run       (run),
    .clear_cnt (clear_cnt),
    .stop_cnt  (stop_cnt),
    .ready     (ready),
    .miss_mask (miss_mask),
    .shot_count(shot_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state == s) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (state == s) ok = 1'b1;
  endtask

  task automatic test_reset();
    ares = 1'b1;
    step();
    step();
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", state); end
    nvec++; if (clear_cnt !== 1'b0) begin nerr++; $display("FAIL reset_clear got %b want 0", clear_cnt); end
    nvec++; if (stop_cnt !== 1'b0) begin nerr++; $display("FAIL reset_stop got %b want 0", stop_cnt); end
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b want 0", ready); end
    nvec++; if (miss_mask !== 4'h0) begin nerr++; $display("FAIL reset_miss got %h want 0", miss_mask); end
    nvec++; if (shot_count !== 8'h00) begin nerr++; $display("FAIL reset_count got %h want 00", shot_count); end
    ares = 1'b0;
    step();
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL reset_release_state got %0d want 0", state); end
  endtask

  task automatic test_four_sensor();
    int stop_at = -1;
    int stops = 0;
    int clears = 0;
    bit ok;
    arm = 1'b1;
    step();
    arm = 1'b0;
    nvec++; if (clear_cnt !== 1'b1) begin nerr++; $display("FAIL four_clear got %b want 1", clear_cnt); end
    nvec++; if (state !== 3'd1) begin nerr++; $display("FAIL four_armed got %0d want 1", state); end
    for (int c = 1; c <= 45; c++) begin
      run = (c >= 40) ? 4'hF : (c >= 30) ? 4'h7 : (c >= 20) ? 4'h3 : (c >= 10) ? 4'h1 : 4'h0;
      step();
      if (stop_cnt) begin
        stops++;
        if (stop_at < 0) stop_at = c;
      end
      if (clear_cnt) clears++;
    end
    nvec++; if (stop_at < 40 || stop_at > 42) begin nerr++; $display("FAIL four_stop_latency got %0d want 40..42", stop_at); end
    nvec++; if (stops !== 1) begin nerr++; $display("FAIL four_stop_pulses got %0d want 1", stops); end
    nvec++; if (clears !== 0) begin nerr++; $display("FAIL four_extra_clear got %0d want 0", clears); end
    nvec++; if (miss_mask !== 4'h0) begin nerr++; $display("FAIL four_miss got %b want 0000", miss_mask); end
    nvec++; if (shot_count !== 8'd1) begin nerr++; $display("FAIL four_count got %0d want 1", shot_count); end
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL four_ready got %b want 1", ready); end
    wait_state(3'd5, 40, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL four_reach_done got %0d want 5", state); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    run = 4'h0;
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL four_ack_state got %0d want 0", state); end
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL four_ack_ready got %b want 0", ready); end
  endtask

  task automatic test_timeout_holdoff();
    int e = -1;
    int c = -1;
    int hold = 0;
    int captures = 0;
    int ready_low = 0;
    int left_holdoff = 0;
    arm = 1'b1;
    run = 4'b0101;
    step();
    arm = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (state == 3'd2 && e < 0) e = k;
      if (state == 3'd3) begin
        c = k;
        break;
      end
    end
    nvec++; if (c - e != TimeoutCyc || e < 0) begin nerr++; $display("FAIL timeout_len got %0d want %0d", c - e, TimeoutCyc); end
    nvec++; if (miss_mask !== 4'b1010) begin nerr++; $display("FAIL timeout_miss got %b want 1010", miss_mask); end
    nvec++; if (stop_cnt !== 1'b1) begin nerr++; $display("FAIL timeout_stop got %b want 1", stop_cnt); end
    nvec++; if (shot_count !== 8'd2) begin nerr++; $display("FAIL timeout_count got %0d want 2", shot_count); end
    for (int k = 0; k < int'(HoldoffCyc) + 6; k++) begin
      run = k[0] ? 4'hF : 4'h0;
      ack = (k == 3);
      step();
      ack = 1'b0;
      if (state == 3'd4) begin
        hold++;
        if (!ready) ready_low++;
      end
      if (state != 3'd4 && state != 3'd5) left_holdoff++;
      if (stop_cnt) captures++;
    end
    nvec++; if (hold !== int'(HoldoffCyc)) begin nerr++; $display("FAIL holdoff_len got %0d want %0d", hold, HoldoffCyc); end
    nvec++; if (captures !== 0) begin nerr++; $display("FAIL holdoff_recapture got %0d want 0", captures); end
    nvec++; if (left_holdoff !== 0) begin nerr++; $display("FAIL holdoff_bad_state got %0d want 0", left_holdoff); end
    nvec++; if (ready_low !== 0) begin nerr++; $display("FAIL holdoff_ready_drop got %0d want 0", ready_low); end
    nvec++; if (state !== 3'd5) begin nerr++; $display("FAIL holdoff_done got %0d want 5", state); end
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL done_ready got %b want 1", ready); end
    nvec++; if (shot_count !== 8'd2) begin nerr++; $display("FAIL holdoff_count got %0d want 2", shot_count); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    run = 4'h0;
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL timeout_ack_state got %0d want 0", state); end
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL timeout_ack_ready got %b want 0", ready); end
  endtask

  task automatic test_abort();
    bit ok;
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL abort_idle_state got %0d want 0", state); end
    nvec++; if (clear_cnt !== 1'b0) begin nerr++; $display("FAIL abort_idle_clear got %b want 0", clear_cnt); end
    arm = 1'b1;
    step();
    arm = 1'b0;
    run = 4'h1;
    wait_state(3'd2, 20, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL abort_reach_measure got %0d want 2", state); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL abort_meas_state got %0d want 0", state); end
    nvec++; if (stop_cnt !== 1'b1) begin nerr++; $display("FAIL abort_meas_stop got %b want 1", stop_cnt); end
    nvec++; if (shot_count !== 8'd2) begin nerr++; $display("FAIL abort_count got %0d want 2", shot_count); end
    nvec++; if (miss_mask !== 4'b1010) begin nerr++; $display("FAIL abort_miss got %b want 1010", miss_mask); end
    step();
    run = 4'h0;
    nvec++; if (stop_cnt !== 1'b0) begin nerr++; $display("FAIL abort_stop_width got %b want 0", stop_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int stops = 0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    run = 4'h1;
    wait_state(3'd2, 20, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL ares_reach_measure got %0d want 2", state); end
    step();
    #2;
    ares = 1'b1;
    #1;
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL ares_async_state got %0d want 0", state); end
    nvec++; if (shot_count !== 8'h00) begin nerr++; $display("FAIL ares_async_count got %h want 00", shot_count); end
    nvec++; if (miss_mask !== 4'h0) begin nerr++; $display("FAIL ares_async_miss got %b want 0000", miss_mask); end
    nvec++; if (stop_cnt !== 1'b0 || clear_cnt !== 1'b0 || ready !== 1'b0) begin
      nerr++; $display("FAIL ares_async_pulses got stop=%b clear=%b ready=%b want 0 0 0", stop_cnt, clear_cnt, ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (stop_cnt) stops++;
    end
    ares = 1'b0;
    run = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      if (stop_cnt) stops++;
    end
    run = 4'h0;
    nvec++; if (stops !== 0) begin nerr++; $display("FAIL ares_no_stop got %0d want 0", stops); end
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL ares_stays_idle got %0d want 0", state); end
  endtask

  task automatic test_auto_rearm();
    bit ok;
    int bad = 0;
    ares = 1'b1;
    step();
    ares = 1'b0;
    auto_rearm = 1'b1;
    run = 4'hF;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      wait_state(3'd5, 40, ok);
      if (!ok) bad++;
      if (shot_count != 8'(i)) bad++;
      if (i == 256) begin
        auto_rearm = 1'b0;
        ack = 1'b1;
      end
      step();
      ack = 1'b0;
      if (i < 256 && (state != 3'd1 || clear_cnt != 1'b1)) bad++;
    end
    run = 4'h0;
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL auto_rearm_shots got %0d bad shots want 0", bad); end
    nvec++; if (shot_count !== 8'h00) begin nerr++; $display("FAIL auto_wrap_count got %h want 00", shot_count); end
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL auto_final_state got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_four_sensor();
    test_timeout_holdoff();
    test_abort();
    test_async_reset();
    test_auto_rearm();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
